// File: rtl/argmin_select.sv
// argmin_select: streaming arg-min over one batch of IEEE-754 single squared
// distances. It collects beats until tlast, then holds {index, min, flags}
// until the result is taken downstream.
// Optional build macro: ARGMIN_NAN_FILTER_EN. When defined, NaN beats are
// counted but never selected, and an all-NaN batch raises error_out.
module argmin_select #(
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk_100mhz,
  input  logic                 rst_in,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [IDX_WIDTH-1:0] m_axis_tindex,
  output logic [31:0]          m_axis_tmin,
  output logic                 overflow_out,
  output logic                 error_out
);

  localparam logic [IDX_WIDTH-1:0] IDX_MAX  = {IDX_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_s_ready;
  logic   w_m_valid;
  logic   w_accept;
  logic   w_release;
  logic   w_beat_ok;

  // r_count is the index the next accepted beat gets; r_full marks that the
  // index space is used up, so any further beat is an overflow beat.
  logic [IDX_WIDTH-1:0] r_count;
  logic                 r_full;
  logic [31:0]          r_min;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_ovf;
  logic                 r_seen;

  logic [IDX_WIDTH-1:0] w_cnt_nxt;
  logic                 w_full_nxt;
  logic [31:0]          w_min_nxt;
  logic [IDX_WIDTH-1:0] w_idx_nxt;
  logic                 w_ovf_nxt;
  logic                 w_seen_nxt;

`ifdef ARGMIN_NAN_FILTER_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic r_err;
  logic w_err_nxt;

  // Exponent all ones with a nonzero mantissa.
  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign w_beat_ok = !is_nan(s_axis_tdata);
  assign error_out = r_err;
`else
  assign w_beat_ok = 1'b1;
  assign error_out = 1'b0;
`endif

  assign w_accept      = s_axis_tvalid && w_s_ready;
  assign w_release     = m_axis_tready && w_m_valid;
  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tindex = r_idx;
  assign m_axis_tmin   = r_min;
  assign overflow_out  = r_ovf;

  // State register.
  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from the state register.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    case (r_state)
      COLLECT: begin
        w_s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      HOLD: begin
        w_m_valid = 1'b1;
        if (m_axis_tready) begin
          w_state_nxt = COLLECT;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // Next datapath values: clear on result handshake, update on accepted beat.
  always_comb begin
    w_cnt_nxt  = r_count;
    w_full_nxt = r_full;
    w_min_nxt  = r_min;
    w_idx_nxt  = r_idx;
    w_ovf_nxt  = r_ovf;
    w_seen_nxt = r_seen;
`ifdef ARGMIN_NAN_FILTER_EN
    w_err_nxt  = r_err;
`endif
    if (w_release) begin
      w_cnt_nxt  = IDX_ZERO;
      w_full_nxt = 1'b0;
      w_min_nxt  = 32'h0000_0000;
      w_idx_nxt  = IDX_ZERO;
      w_ovf_nxt  = 1'b0;
      w_seen_nxt = 1'b0;
`ifdef ARGMIN_NAN_FILTER_EN
      w_err_nxt  = 1'b0;
`endif
    end else if (w_accept) begin
      // Counter saturates; the beat that arrives once saturated overflows
      // but is still compared under the saturated index.
      if (r_full) begin
        w_ovf_nxt = 1'b1;
      end else if (r_count == IDX_MAX) begin
        w_full_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_count + IDX_ONE;
      end
      // Magnitude compare on bits [30:0]; strict less keeps the earlier tie.
      if (w_beat_ok && (!r_seen || (s_axis_tdata[30:0] < r_min[30:0]))) begin
        w_min_nxt  = s_axis_tdata;
        w_idx_nxt  = r_count;
        w_seen_nxt = 1'b1;
      end else begin
        w_seen_nxt = r_seen;
      end
`ifdef ARGMIN_NAN_FILTER_EN
      // Batch closed without a single usable beat: report the canonical NaN.
      if (s_axis_tlast && !w_seen_nxt) begin
        w_min_nxt = QNAN;
        w_idx_nxt = IDX_ZERO;
        w_err_nxt = 1'b1;
      end else begin
        w_err_nxt = r_err;
      end
`endif
    end else begin
      w_cnt_nxt = r_count;
    end
  end

  // Datapath registers; reset discards any partial or pending result.
  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      r_count <= IDX_ZERO;
      r_full  <= 1'b0;
      r_min   <= 32'h0000_0000;
      r_idx   <= IDX_ZERO;
      r_ovf   <= 1'b0;
      r_seen  <= 1'b0;
`ifdef ARGMIN_NAN_FILTER_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_count <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      r_min   <= w_min_nxt;
      r_idx   <= w_idx_nxt;
      r_ovf   <= w_ovf_nxt;
      r_seen  <= w_seen_nxt;
`ifdef ARGMIN_NAN_FILTER_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_argmin_select.sv
// tb_argmin_select: directed table-driven bench for argmin_select.
// Two instances share the stimulus: the default width (8) and width 2, the
// latter to exercise counter saturation and overflow.
module tb_argmin_select;

`ifdef ARGMIN_NAN_FILTER_EN
  localparam logic NAN_ERR = 1'b1;
`else
  localparam logic NAN_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = 32'h0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        s_tready, m_tvalid, ovf, err;
  logic [7:0]  m_tindex;
  logic [31:0] m_tmin;
  logic        s_tready2, m_tvalid2, ovf2, err2;
  logic [1:0]  m_tindex2;
  logic [31:0] m_tmin2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  argmin_select #(.IDX_WIDTH(8)) dut (
    .clk_100mhz(clk), .rst_in(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tindex(m_tindex), .m_axis_tmin(m_tmin),
    .overflow_out(ovf), .error_out(err)
  );

  argmin_select #(.IDX_WIDTH(2)) dut2 (
    .clk_100mhz(clk), .rst_in(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
    .m_axis_tindex(m_tindex2), .m_axis_tmin(m_tmin2),
    .overflow_out(ovf2), .error_out(err2)
  );

  typedef struct {
    int          first;
    int          n;
    bit          gap;
    logic [31:0] idx8;
    logic [31:0] mn;
    logic        err;
    logic [31:0] idx2;
    logic        ovf2;
  } vec_t;

  logic [31:0] beats [0:29];
  vec_t        vecs  [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Called at a negedge with the result held; takes it and checks the return.
  task automatic handshake(input string tag);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    chk($sformatf("%s_sready", tag), {31'd0, s_tready}, 32'd1);
    chk($sformatf("%s_mvalid", tag), {31'd0, m_tvalid}, 32'd0);
    chk($sformatf("%s_mvalid2", tag), {31'd0, m_tvalid2}, 32'd0);
  endtask

  initial begin
    beats = '{32'h40000000, 32'h3F800000, 32'h40800000,
              32'h3F000000, 32'h3F000000,
              32'h40800000,
              32'h40000000, 32'hBF800000,
              32'h41000000, 32'h40E00000, 32'h40C00000, 32'h3E800000,
              32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40400000,
              32'h7FC00000, 32'h40000000,
              32'h7FC00000,
              32'h40C00000, 32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    //          first n  gap   idx8    min            err      idx2   ovf2
    vecs[0] = '{0,  3, 1'b0, 32'd1, 32'h3F800000, 1'b0,    32'd1, 1'b0};
    vecs[1] = '{3,  2, 1'b0, 32'd0, 32'h3F000000, 1'b0,    32'd0, 1'b0};
    vecs[2] = '{5,  1, 1'b0, 32'd0, 32'h40800000, 1'b0,    32'd0, 1'b0};
    vecs[3] = '{6,  2, 1'b0, 32'd1, 32'hBF800000, 1'b0,    32'd1, 1'b0};
    vecs[4] = '{8,  4, 1'b1, 32'd3, 32'h3E800000, 1'b0,    32'd3, 1'b0};
    vecs[5] = '{12, 5, 1'b0, 32'd0, 32'h3F800000, 1'b0,    32'd0, 1'b1};
    vecs[6] = '{17, 4, 1'b1, 32'd1, 32'h3F800000, 1'b0,    32'd1, 1'b0};
    vecs[7] = '{21, 2, 1'b0, 32'd1, 32'h40000000, 1'b0,    32'd1, 1'b0};
    vecs[8] = '{23, 1, 1'b0, 32'd0, 32'h7FC00000, NAN_ERR, 32'd0, 1'b0};
    vecs[9] = '{24, 6, 1'b0, 32'd5, 32'h3F800000, 1'b0,    32'd3, 1'b1};

    // Reset state: clock edge at t=5 applies the held reset.
    @(negedge clk);
    chk("rst_sready", {31'd0, s_tready}, 32'd1);
    chk("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_index", {24'd0, m_tindex}, 32'd0);
    chk("rst_min", m_tmin, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Table-driven batches; result must be valid one cycle after tlast.
    for (int v = 0; v < 10; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        if (vecs[v].gap && (b > 0)) idle();
        send_beat(beats[vecs[v].first + b], (b == vecs[v].n - 1));
      end
      idle();
      chk($sformatf("v%0d_mvalid", v), {31'd0, m_tvalid}, 32'd1);
      chk($sformatf("v%0d_sready", v), {31'd0, s_tready}, 32'd0);
      chk($sformatf("v%0d_index", v), {24'd0, m_tindex}, vecs[v].idx8);
      chk($sformatf("v%0d_min", v), m_tmin, vecs[v].mn);
      chk($sformatf("v%0d_ovf", v), {31'd0, ovf}, 32'd0);
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].err});
      chk($sformatf("v%0d_index_w2", v), {30'd0, m_tindex2}, vecs[v].idx2);
      chk($sformatf("v%0d_min_w2", v), m_tmin2, vecs[v].mn);
      chk($sformatf("v%0d_ovf_w2", v), {31'd0, ovf2}, {31'd0, vecs[v].ovf2});
      chk($sformatf("v%0d_err_w2", v), {31'd0, err2}, {31'd0, vecs[v].err});
      handshake($sformatf("v%0d_hs", v));
    end

    // Held result under back-pressure, with a smaller beat offered meanwhile.
    send_beat(32'h40800000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 32'h00000000;
      s_tlast  = 1'b1;
      chk($sformatf("hold%0d_mvalid", k), {31'd0, m_tvalid}, 32'd1);
      chk($sformatf("hold%0d_sready", k), {31'd0, s_tready}, 32'd0);
      chk($sformatf("hold%0d_index", k), {24'd0, m_tindex}, 32'd0);
      chk($sformatf("hold%0d_min", k), m_tmin, 32'h40800000);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("hold_last_min", m_tmin, 32'h40800000);
    handshake("hold_hs");
    chk("hold_cleared_min", m_tmin, 32'd0);
    chk("hold_cleared_index", {24'd0, m_tindex}, 32'd0);

    // Reset mid-batch discards the partial batch.
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h3F000000, 1'b0);
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_sready", {31'd0, s_tready}, 32'd1);
    chk("midrst_mvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_min", m_tmin, 32'd0);
    chk("midrst_index", {24'd0, m_tindex}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_beat(32'h40000000, 1'b1);
    idle();
    chk("midrst_res_mvalid", {31'd0, m_tvalid}, 32'd1);
    chk("midrst_res_index", {24'd0, m_tindex}, 32'd0);
    chk("midrst_res_min", m_tmin, 32'h40000000);
    chk("midrst_res_ovf", {31'd0, ovf}, 32'd0);
    handshake("midrst_hs");

    // Reset while holding a result drops it.
    send_beat(32'h3F800000, 1'b1);
    idle();
    chk("holdrst_pre_mvalid", {31'd0, m_tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("holdrst_mvalid", {31'd0, m_tvalid}, 32'd0);
    chk("holdrst_sready", {31'd0, s_tready}, 32'd1);
    chk("holdrst_min", m_tmin, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_beat(32'h40400000, 1'b1);
    idle();
    chk("holdrst_res_mvalid", {31'd0, m_tvalid}, 32'd1);
    chk("holdrst_res_index", {24'd0, m_tindex}, 32'd0);
    chk("holdrst_res_min", m_tmin, 32'h40400000);
    handshake("holdrst_hs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
